// File: rtl/absval_sched_pkg.sv
// Shared types and default sizing for the absval_sched round-robin abs-value scheduler.
package absval_sched_pkg;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefNumReq = 4;
  localparam int unsigned DefIdW    = $clog2(DefNumReq);

  typedef logic [DefWidth-1:0] operand_t;

  // Pipeline payload at the default configuration.
  typedef struct packed {
    operand_t            data;
    logic [DefIdW-1:0]   id;
    logic                ovf;
  } s_payload_t;

endpackage

// File: rtl/AbsVal.sv
// Two's-complement absolute value: bit i flips when negative and any lower bit is set.
module AbsVal
  import absval_sched_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Speed = 1
) (
  input  logic [Width-1:0] i_a,
  output logic [Width-1:0] o_z,
  output logic             o_ovf
);

  // w_zero[i] is set when i_a[i:0] is all zeros.
  logic [Width-1:0] w_zero;

  PrefixAnd #(
    .Width(Width),
    .Speed(Speed)
  ) u_prefix (
    .i_a(~i_a),
    .o_z(w_zero)
  );

  always_comb begin
    o_z    = i_a;
    for (int i = 1; i < int'(Width); i++) begin
      o_z[i] = i_a[i] ^ (i_a[Width-1] & ~w_zero[i-1]);
    end
    o_ovf = i_a[Width-1] & w_zero[Width-2];
  end

endmodule

// File: rtl/PrefixAnd.sv
// Prefix AND: o_z[i] = &i_a[i:0]. Speed selects serial (0), Brent-Kung (1) or Sklansky (2).
module PrefixAnd
  import absval_sched_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Speed = 1
) (
  input  logic [Width-1:0] i_a,
  output logic [Width-1:0] o_z
);

  localparam int Levels = (Width > 1) ? $clog2(Width) : 1;

  // Index of the partner bit s positions below i, clamped so unused branches stay in range.
  function automatic int lo(input int i, input int s);
    return (i >= s) ? i - s : i;
  endfunction

  function automatic int sk_src(input int i, input int l);
    return (((i >> l) & 1) == 1) ? ((i >> l) << l) - 1 : i;
  endfunction

  logic [Width-1:0] w_t;
  logic [Width-1:0] w_n;

  always_comb begin
    w_t = i_a;
    w_n = i_a;
    if (Speed == 0) begin
      for (int i = 1; i < int'(Width); i++) begin
        w_t[i] = w_t[i-1] & i_a[i];
      end
    end else if (Speed == 2) begin
      for (int l = 0; l < Levels; l++) begin
        w_n = w_t;
        for (int i = 0; i < int'(Width); i++) begin
          if (((i >> l) & 1) == 1) w_n[i] = w_t[i] & w_t[sk_src(i, l)];
        end
        w_t = w_n;
      end
    end else begin
      // Up-sweep builds power-of-two block ANDs, down-sweep fills the gaps.
      for (int l = 0; l < Levels; l++) begin
        w_n = w_t;
        for (int i = 0; i < int'(Width); i++) begin
          if (((i + 1) % (1 << (l + 1))) == 0) w_n[i] = w_t[i] & w_t[lo(i, 1 << l)];
        end
        w_t = w_n;
      end
      for (int l = Levels - 2; l >= 0; l--) begin
        w_n = w_t;
        for (int i = 0; i < int'(Width); i++) begin
          if ((i >= (1 << (l + 1))) && (((i + 1) % (1 << (l + 1))) == (1 << l))) begin
            w_n[i] = w_t[i] & w_t[lo(i, 1 << l)];
          end
        end
        w_t = w_n;
      end
    end
    o_z = w_t;
  end

endmodule

// File: rtl/absval_rr_arb.sv
// Combinational round-robin arbiter: first valid requester at or above i_ptr, wrapping.
module absval_rr_arb
  import absval_sched_pkg::*;
#(
  parameter int unsigned NumReq = DefNumReq,
  parameter int unsigned IdW    = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] i_valid,
  input  logic [IdW-1:0]    i_ptr,
  input  logic              i_en,
  output logic [NumReq-1:0] o_gnt,
  output logic [IdW-1:0]    o_idx
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < int'(NumReq); k++) begin
      for (int i = 0; i < int'(NumReq); i++) begin
        if (!w_found && i_en && i_valid[i] &&
            (i == ((int'(i_ptr) + k) % int'(NumReq)))) begin
          o_gnt[i] = 1'b1;
          o_idx    = IdW'(i);
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/absval_sched.sv
// Round-robin scheduler sharing one AbsVal across NumReq requesters via a 2-stage pipeline.
// Define ABSVAL_SCHED_SAT_EN to saturate the most-negative operand to the largest positive value.
module absval_sched
  import absval_sched_pkg::*;
#(
  parameter int unsigned Width  = DefWidth,
  parameter int unsigned Speed  = 1,
  parameter int unsigned NumReq = DefNumReq,
  parameter int unsigned IdW    = $clog2(NumReq)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq-1:0][Width-1:0] req_data_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [Width-1:0]             rsp_data_o,
  output logic [IdW-1:0]               rsp_id_o,
  output logic                         rsp_ovf_o
);

  typedef struct packed {
    logic [Width-1:0] data;
    logic [IdW-1:0]   id;
    logic             ovf;
  } payload_t;

  logic             r_s1_valid;
  logic [Width-1:0] r_s1_data;
  logic [IdW-1:0]   r_s1_id;
  logic             r_s2_valid;
  payload_t         r_s2;
  logic [IdW-1:0]   r_ptr;

  logic              w_s2_rdy;
  logic              w_s1_rdy;
  logic [NumReq-1:0] w_gnt;
  logic [IdW-1:0]    w_idx;
  logic              w_hs;
  logic [IdW-1:0]    w_next_ptr;
  logic [Width-1:0]  w_abs;
  logic [Width-1:0]  w_res;
  logic              w_ovf;

  assign w_s2_rdy = !r_s2_valid || rsp_ready_i;
  assign w_s1_rdy = !r_s1_valid || w_s2_rdy;

  absval_rr_arb #(
    .NumReq(NumReq),
    .IdW   (IdW)
  ) u_arb (
    .i_valid(req_valid_i),
    .i_ptr  (r_ptr),
    .i_en   (w_s1_rdy),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );

  assign req_ready_o = w_gnt;
  assign w_hs        = |w_gnt;
  assign w_next_ptr  = (w_idx == IdW'(NumReq - 1)) ? '0 : w_idx + 1'b1;

  AbsVal #(
    .Width(Width),
    .Speed(Speed)
  ) u_abs (
    .i_a  (r_s1_data),
    .o_z  (w_abs),
    .o_ovf(w_ovf)
  );

`ifdef ABSVAL_SCHED_SAT_EN
  assign w_res = w_ovf ? {1'b0, {(Width - 1){1'b1}}} : w_abs;
`else
  assign w_res = w_abs;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= w_next_ptr;
    end
  end

  // S1 empties into S2 whenever it is ready, so it only stays valid on a new grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_id    <= '0;
    end else if (w_s1_rdy) begin
      r_s1_valid <= w_hs;
      if (w_hs) begin
        r_s1_data <= req_data_i[w_idx];
        r_s1_id   <= w_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_s2_rdy) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2.data <= w_res;
        r_s2.id   <= r_s1_id;
        r_s2.ovf  <= w_ovf;
      end
    end
  end

  assign rsp_valid_o = r_s2_valid;
  assign rsp_data_o  = r_s2.data;
  assign rsp_id_o    = r_s2.id;
  assign rsp_ovf_o   = r_s2.ovf;

endmodule

// File: tb/tb_absval_sched.sv
// Bench for absval_sched: three DUTs (Speed 0/1/2) on shared stimulus against a queue model.
module tb_absval_sched;
  import absval_sched_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [3:0][7:0] req_data;
  logic            rsp_ready;

  logic [3:0] ready_o [3];
  logic       rvalid  [3];
  logic [7:0] rdata   [3];
  logic [1:0] rid     [3];
  logic       rovf    [3];

  for (genvar s = 0; s < 3; s++) begin : g_dut
    absval_sched #(
      .Width (8),
      .Speed (s),
      .NumReq(4)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_valid_i(req_valid),
      .req_ready_o(ready_o[s]),
      .req_data_i (req_data),
      .rsp_valid_o(rvalid[s]),
      .rsp_ready_i(rsp_ready),
      .rsp_data_o (rdata[s]),
      .rsp_id_o   (rid[s]),
      .rsp_ovf_o  (rovf[s])
    );
  end

  always #5 clk = ~clk;

  typedef struct {
    s_payload_t p;
    int         acc;
  } exp_t;

  exp_t       q[$];
  int         ptr_m;
  int         edges;
  int         last_grant;
  bit         pend[4];
  logic [7:0] dat[4];
  int         n_checks;
  int         n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // |A| modulo 2^8, with the most-negative operand flagged.
  function automatic s_payload_t ref_abs(input logic [7:0] d, input int id);
    s_payload_t p;
    int v;
    v     = int'($signed(d));
    p.id  = 2'(id);
    p.ovf = (v == -128);
    if (v < 0) v = -v;
    p.data = 8'(v);
`ifdef ABSVAL_SCHED_SAT_EN
    if (p.ovf) p.data = 8'h7F;
`endif
    return p;
  endfunction

  function automatic int exp_grant();
    for (int k = 0; k < 4; k++) begin
      if (pend[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
    end
    return -1;
  endfunction

  // One clock: drive, check before the edge, update the model after it.
  task automatic cycle();
    int         g;
    bit         s1_rdy;
    bit         vexp;
    logic [3:0] rexp;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = pend[i];
      req_data[i]  = dat[i];
    end
    #1;
    s1_rdy = (q.size() < 2) || rsp_ready;
    g      = exp_grant();
    rexp   = '0;
    if (s1_rdy && g >= 0) rexp[g] = 1'b1;
    vexp = (q.size() > 0) && (edges >= q[0].acc + 1);
    for (int s = 0; s < 3; s++) begin
      chk("req_ready", 32'(ready_o[s]), 32'(rexp));
      chk("rsp_valid", 32'(rvalid[s]), 32'(vexp));
      if (vexp) begin
        chk("rsp_data", 32'(rdata[s]), 32'(q[0].p.data));
        chk("rsp_id", 32'(rid[s]), 32'(q[0].p.id));
        chk("rsp_ovf", 32'(rovf[s]), 32'(q[0].p.ovf));
      end
    end
    @(posedge clk);
    edges++;
    if (vexp && rsp_ready) void'(q.pop_front());
    last_grant = -1;
    if (rexp != 4'b0) begin
      exp_t e;
      e.p   = ref_abs(dat[g], g);
      e.acc = edges;
      q.push_back(e);
      pend[g]    = 1'b0;
      ptr_m      = (g + 1) % 4;
      last_grant = g;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    q.delete();
    ptr_m = 0;
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int bound);
    int left;
    rsp_ready = 1'b1;
    for (int c = 0; c < bound; c++) begin
      left = q.size();
      for (int i = 0; i < 4; i++) left += int'(pend[i]);
      if (left == 0) break;
      cycle();
    end
    left = q.size();
    for (int i = 0; i < 4; i++) left += int'(pend[i]);
    chk("drain_left", 32'(left), 32'd0);
  endtask

  initial begin
    int prev;
    int waited;
    n_checks   = 0;
    n_pass     = 0;
    edges      = 0;
    ptr_m      = 0;
    last_grant = -1;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0;
      dat[i]  = '0;
    end
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_valid", 32'(rvalid[s]), 32'd0);
      chk("rst_data", 32'(rdata[s]), 32'd0);
      chk("rst_id", 32'(rid[s]), 32'd0);
      chk("rst_ovf", 32'(rovf[s]), 32'd0);
      chk("rst_ready_idle", 32'(ready_o[s]), 32'd0);
    end
    req_valid = 4'b0001;
    #1;
    chk("rst_ready_empty", 32'(ready_o[1]), 32'b0001);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single operand: 0xF6 -> 0x0A two edges after acceptance.
    rsp_ready = 1'b1;
    pend[0]   = 1'b1;
    dat[0]    = 8'hF6;
    cycle();
    cycle();
    chk("t1_valid", 32'(rvalid[1]), 32'd1);
    chk("t1_data", 32'(rdata[1]), 32'h0A);
    chk("t1_id", 32'(rid[1]), 32'd0);
    chk("t1_ovf", 32'(rovf[1]), 32'd0);
    drain(10);

    // All four requesters from a fresh pointer: grants in index order.
    do_reset();
    rsp_ready = 1'b1;
    dat[0] = 8'h05; dat[1] = 8'hFB; dat[2] = 8'h80; dat[3] = 8'h7F;
    for (int i = 0; i < 4; i++) pend[i] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_order", 32'(last_grant), 32'(i));
    end
    drain(10);

    // Backpressure: three offered, two absorbed, then a full stall.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b1;
      dat[i]  = 8'($urandom);
    end
    repeat (5) cycle();
    #1;
    chk("bp_stall_ready", 32'(ready_o[1]), 32'd0);
    chk("bp_stall_valid", 32'(rvalid[1]), 32'd1);
    drain(20);

    // Fairness between requesters 1 and 3, then requester 0 joins.
    rsp_ready = 1'b1;
    prev      = -1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 1; i < 4; i += 2) begin
        if (!pend[i]) begin
          pend[i] = 1'b1;
          dat[i]  = 8'($urandom);
        end
      end
      cycle();
      chk("fair_alt", 32'(((last_grant == 1) || (last_grant == 3)) && (last_grant != prev)),
          32'd1);
      prev = last_grant;
    end
    pend[0] = 1'b1;
    dat[0]  = 8'($urandom);
    waited  = 0;
    while (pend[0] && waited < 8) begin
      for (int i = 1; i < 4; i += 2) begin
        if (!pend[i]) begin
          pend[i] = 1'b1;
          dat[i]  = 8'($urandom);
        end
      end
      cycle();
      waited++;
    end
    chk("fair_r0_within", 32'(waited <= 4 && !pend[0]), 32'd1);
    pend[1] = 1'b0;
    pend[3] = 1'b0;
    drain(20);

    // Random traffic with random consumer stalls.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          dat[i]  = 8'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain(40);

    // Asynchronous reset with both stages full.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b1;
      dat[i]  = 8'($urandom);
    end
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) chk("arst_valid_drop", 32'(rvalid[s]), 32'd0);
    q.delete();
    ptr_m = 0;
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    pend[1] = 1'b1; dat[1] = 8'h9C;
    pend[3] = 1'b1; dat[3] = 8'h33;
    cycle();
    chk("arst_first_grant", 32'(last_grant), 32'd1);
    drain(10);

    // Exhaustive operand sweep through requester 2.
    rsp_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      pend[2] = 1'b1;
      dat[2]  = 8'(v);
      cycle();
    end
    drain(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
